vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 Hz raster timing from the 100 MHz system clock.
- Drives the pixel coordinate bus (x, y, display_on) that feeds game_display, plus the hsync and vsync pins.
- Also provides a pixel-rate strobe and a one-clock end-of-frame pulse for frame-rate game logic.

Parameters:
- CLK_DIV, 4, system clocks per pixel (4 gives 25 MHz at 100 MHz); legal values 1..16.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BACK, 33, vertical back porch, in lines.

Ports:
- clock  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- pixel_tick  output  1  high for one clock per pixel period.
- x  output  10  horizontal counter, 0..H_TOTAL-1.
- y  output  10  vertical counter, 0..V_TOTAL-1.
- display_on  output  1  high when x < H_DISPLAY and y < V_DISPLAY.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- frame_tick  output  1  one-clock pulse on the last pixel of each frame.

Behaviour:
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
  - Both must fit in 10 bits; all counters are 10-bit unsigned.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 and wraps to 0.
  - pixel_tick = (div_cnt == CLK_DIV-1), combinational from the registered div_cnt.
  - CLK_DIV=1 holds pixel_tick permanently high after reset.
- Horizontal counter: advances only on clocks with pixel_tick=1. At H_TOTAL-1 it wraps to 0 and the vertical counter advances.
- Vertical counter: wraps from V_TOTAL-1 to 0 on the same clock the horizontal counter wraps.
- x and y are the registered counters themselves, held constant for CLK_DIV clocks.
- Sync generation:
  - hsync and vsync are registered.
  - Each is computed from the next-state counter values, so it changes on the same clock edge as x and y, with zero skew.
  - hsync = 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
  - vsync depends only on y, so it changes at line boundaries (x=0).
- display_on: combinational from the registered x and y.
- frame_tick: combinational, = pixel_tick & (x == H_TOTAL-1) & (y == V_TOTAL-1). It is exactly one clock wide per frame, independent of CLK_DIV.
- Reset (reset=0 at a clock edge), applies at any point including mid-line or mid-frame, with no partial-frame artefacts after release:
  - div_cnt=0, x=0, y=0, hsync=1, vsync=1.
  - Outputs while held: display_on=1 (follows x=y=0), pixel_tick=0 for CLK_DIV>1, frame_tick=0.
- After reset release: the first pixel_tick occurs on the CLK_DIV-th clock, and x becomes 1 on the following edge.
- Line period = H_TOTAL*CLK_DIV clocks (3200). Frame period = H_TOTAL*V_TOTAL*CLK_DIV clocks (1,680,000).
- No input other than reset affects timing; there is no handshake.

Test Plan:
- Reset values:
  - Hold reset=0 for 5 clocks mid-frame (x=300, y=200).
  - Required: x=0, y=0, hsync=1, vsync=1, display_on=1, frame_tick=0 during reset.
  - Required after release: x=1 exactly 4 clocks later (CLK_DIV=4).
- Pixel cadence:
  - Free-run 40 clocks after reset.
  - Required: pixel_tick high on clocks 3, 7, 11, ... (one in four).
  - Required: x increments only on the edge following each pixel_tick, and holds for 4 clocks.
- Horizontal timing, over one line:
  - Required: hsync falls on the edge where x becomes 656 and rises where x becomes 752, giving a low width of 384 clocks.
  - Required: display_on falls at x=640.
  - Required: x wraps 799 -> 0 while y increments, with a line period of 3200 clocks.
- Vertical timing and frame, over one full frame:
  - Required: vsync low only for y=490..491 (6400 clocks).
  - Required: display_on high for 307,200 pixel_ticks.
  - Required: frame_tick pulses exactly once, at x=799, y=524, and 1,680,000 clocks separate consecutive frame_ticks.
- CLK_DIV=1 build:
  - Required: pixel_tick constantly 1 after reset.
  - Required: x advances every clock, line period 800 clocks, hsync low for 96 clocks.
- Reset during sync:
  - Assert reset while hsync=0 and vsync=0 (x=700, y=491).
  - Required: hsync and vsync return to 1 on that same edge.
  - Required: the next hsync low begins 656*4 clocks after reset release.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster-position and sync bundle from vga_timing_gen to its consumers
// (game_display, the VGA pins and frame-rate logic).
interface vga_timing_if;
  logic       pixel_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output pixel_tick, x, y, display_on, hsync, vsync, frame_tick
  );

  modport slave (
    input pixel_tick, x, y, display_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides the system clock down to the pixel rate and
// produces x/y counters, zero-skew registered syncs and frame strobes.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         clock,
  input  logic         reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       tick_s;

  assign tick_s = (div_q == DIV_LAST);

  // Next-state counters; syncs decode the next x/y so they switch with them.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (tick_s) begin
      div_d = 4'd0;
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        if (y_q == V_LAST) begin
          y_d = 10'd0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end else begin
      div_d = div_q + 4'd1;
    end
    hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
  end

  // Timing state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q   <= 4'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga.pixel_tick = tick_s;
  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.display_on = (x_q < H_VIS) && (y_q < V_VIS);
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.frame_tick = tick_s && (x_q == H_LAST) && (y_q == V_LAST);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default, CLK_DIV=1, small CLK_DIV=3)
// checked every cycle against a clocks-since-reset arithmetic model.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;
  logic cmp_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k0 = 0;
  int   k1 = 0;
  int   k2 = 0;

  always #5 clk = ~clk;

  vga_timing_if if0();
  vga_timing_if if1();
  vga_timing_if if2();

  vga_timing_gen u0 (.clock(clk), .reset(rst0), .vga(if0));

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
  ) u1 (.clock(clk), .reset(rst1), .vga(if1));

  vga_timing_gen #(
    .CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u2 (.clock(clk), .reset(rst2), .vga(if2));

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       don;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  // Outputs are a pure function of clocks elapsed since the last reset edge.
  function automatic exp_t model(input int k, input int d, input int hd, input int hf,
                                 input int hs, input int hb, input int vd, input int vf,
                                 input int vs, input int vb);
    exp_t e;
    int ht;
    int vt;
    int pix;
    int px;
    int py;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    pix = k / d;
    px  = pix % ht;
    py  = (pix / ht) % vt;
    e.tick = ((k % d) == d - 1);
    e.x    = 10'(px);
    e.y    = 10'(py);
    e.don  = (px < hd) && (py < vd);
    e.hs   = !((px >= hd + hf) && (px < hd + hf + hs));
    e.vs   = !((py >= vd + vf) && (py < vd + vf + vs));
    e.ft   = e.tick && (px == ht - 1) && (py == vt - 1);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t a, input exp_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got tick=%0b x=%0d y=%0d don=%0b hs=%0b vs=%0b ft=%0b, need tick=%0b x=%0d y=%0d don=%0b hs=%0b vs=%0b ft=%0b",
               nm, $time, a.tick, a.x, a.y, a.don, a.hs, a.vs, a.ft,
               e.tick, e.x, e.y, e.don, e.hs, e.vs, e.ft);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, need %0d", nm, $time, act, exp);
    end
  endtask

  // Model time base: count edges since each instance last sampled reset low.
  always @(posedge clk) begin
    k0 <= rst0 ? k0 + 1 : 0;
    k1 <= rst1 ? k1 + 1 : 0;
    k2 <= rst2 ? k2 + 1 : 0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("u0", {if0.pixel_tick, if0.x, if0.y, if0.display_on, if0.hsync, if0.vsync, if0.frame_tick},
          model(k0, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      cmp("u1", {if1.pixel_tick, if1.x, if1.y, if1.display_on, if1.hsync, if1.vsync, if1.frame_tick},
          model(k1, 1, 640, 16, 96, 48, 16, 2, 2, 4));
      cmp("u2", {if2.pixel_tick, if2.x, if2.y, if2.display_on, if2.hsync, if2.vsync, if2.frame_tick},
          model(k2, 3, 16, 2, 4, 3, 12, 2, 2, 3));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("u0_rst_state", {if0.x, if0.y, if0.hsync, if0.vsync, if0.display_on, if0.frame_tick, if0.pixel_tick},
        {10'd0, 10'd0, 5'b11100});
    chk("u1_rst_tick", int'(if1.pixel_tick), 1);
    fork
      begin : thr0
        int n;
        int t;
        int y0;
        rst0 = 1'b1;
        n = 0;
        while (if0.x != 10'd1 && n < 20) begin @(negedge clk); n++; end
        chk("u0_release_x1", n, 4);
        t = 0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          t += int'(if0.pixel_tick);
        end
        chk("u0_ticks_per_40", t, 10);
        n = 0;
        while (if0.display_on && n < 4000) begin @(negedge clk); n++; end
        chk("u0_don_fall_x", int'(if0.x), 640);
        n = 0;
        while (if0.hsync && n < 4000) begin @(negedge clk); n++; end
        chk("u0_hs_fall_x", int'(if0.x), 656);
        n = 0;
        while (!if0.hsync && n < 4000) begin @(negedge clk); n++; end
        chk("u0_hs_low_clks", n, 384);
        chk("u0_hs_rise_x", int'(if0.x), 752);
        y0 = int'(if0.y);
        n = 0;
        while (int'(if0.y) == y0 && n < 4000) begin @(negedge clk); n++; end
        chk("u0_wrap_x", int'(if0.x), 0);
        chk("u0_wrap_y", int'(if0.y), y0 + 1);
        y0 = int'(if0.y);
        n = 0;
        while (int'(if0.y) == y0 && n < 4000) begin @(negedge clk); n++; end
        chk("u0_line_period", n, 3200);
        n = 0;
        while (if0.x != 10'd700 && n < 4000) begin @(negedge clk); n++; end
        chk("u0_pre_sync_hs", int'(if0.hsync), 0);
        rst0 = 1'b0;
        @(negedge clk);
        chk("u0_sync_rst_hs", int'(if0.hsync), 1);
        rst0 = 1'b1;
        n = 0;
        while (if0.hsync && n < 4000) begin @(negedge clk); n++; end
        chk("u0_hs_after_rst", n, 656 * 4);
      end
      begin : thr1
        int n;
        int y0;
        int ft_cnt;
        int don_cnt;
        int vs_cnt;
        rst1 = 1'b1;
        @(negedge clk);
        chk("u1_tick_run", int'(if1.pixel_tick), 1);
        n = 0;
        while (if1.hsync && n < 2000) begin @(negedge clk); n++; end
        n = 0;
        while (!if1.hsync && n < 2000) begin @(negedge clk); n++; end
        chk("u1_hs_low_clks", n, 96);
        y0 = int'(if1.y);
        n = 0;
        while (int'(if1.y) == y0 && n < 2000) begin @(negedge clk); n++; end
        y0 = int'(if1.y);
        n = 0;
        while (int'(if1.y) == y0 && n < 2000) begin @(negedge clk); n++; end
        chk("u1_line_period", n, 800);
        n = 0;
        while (!if1.frame_tick && n < 25000) begin @(negedge clk); n++; end
        chk("u1_ft_x", int'(if1.x), 799);
        chk("u1_ft_y", int'(if1.y), 23);
        ft_cnt = 0;
        don_cnt = 0;
        vs_cnt = 0;
        for (int i = 0; i < 19200; i++) begin
          @(negedge clk);
          ft_cnt  += int'(if1.frame_tick);
          don_cnt += int'(if1.display_on && if1.pixel_tick);
          vs_cnt  += int'(!if1.vsync);
        end
        chk("u1_ft_per_frame", ft_cnt, 1);
        chk("u1_ft_period_end", int'(if1.frame_tick), 1);
        chk("u1_don_ticks", don_cnt, 640 * 16);
        chk("u1_vs_low_clks", vs_cnt, 2 * 800);
      end
      begin : thr2
        int n;
        rst2 = 1'b1;
        n = 0;
        while (!(if2.x == 10'd10 && if2.y == 10'd8) && n < 2000) begin @(negedge clk); n++; end
        chk("u2_mid_reach", n, 3 * (8 * 25 + 10));
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("u2_mid_rst_state", {if2.x, if2.y, if2.hsync, if2.vsync, if2.display_on, if2.frame_tick, if2.pixel_tick},
              {10'd0, 10'd0, 5'b11100});
        end
        rst2 = 1'b1;
        n = 0;
        while (if2.x != 10'd1 && n < 20) begin @(negedge clk); n++; end
        chk("u2_release_x1", n, 3);
        n = 0;
        while (!(!if2.hsync && !if2.vsync) && n < 2000) begin @(negedge clk); n++; end
        chk("u2_in_sync", {30'd0, if2.hsync, if2.vsync}, 0);
        rst2 = 1'b0;
        @(negedge clk);
        chk("u2_sync_rst", {30'd0, if2.hsync, if2.vsync}, 3);
        rst2 = 1'b1;
        n = 0;
        while (if2.hsync && n < 2000) begin @(negedge clk); n++; end
        chk("u2_hs_after_rst", n, 18 * 3);
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(1500, 20)) @(negedge clk);
          rst2 = 1'b0;
          repeat ($urandom_range(5, 1)) @(negedge clk);
          rst2 = 1'b1;
        end
        repeat (1500) @(negedge clk);
      end
    join
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
